// File: rtl/dac_table_8x_dbg_pkg.sv
// Shared types and default widths for the dac_table_8x deadlock reporter.
package dac_table_8x_dbg_pkg;

  localparam int NUM_AXIS_D = 3;
  localparam int THRESH_W_D = 16;
  localparam int DUR_W_D    = 32;
  localparam int EVT_W_D    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUALIFY,
    ST_DEADLOCK,
    ST_RELEASE
  } dl_state_e;

endpackage

// File: rtl/dac_table_8x_deadlock_reporter_if.sv
// Monitor-side inputs and CSR-side outputs of the deadlock reporter.
interface dac_table_8x_deadlock_reporter_if
  import dac_table_8x_dbg_pkg::*;
#(
  parameter int NUM_AXIS = NUM_AXIS_D,
  parameter int THRESH_W = THRESH_W_D,
  parameter int DUR_W    = DUR_W_D,
  parameter int EVT_W    = EVT_W_D
);
  logic                block;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic                enable;
  logic [THRESH_W-1:0] threshold;
  logic                ack;
  logic                irq;
  logic                deadlock_active;
  logic [NUM_AXIS-1:0] chan_snapshot;
  logic [DUR_W-1:0]    stall_cycles;
  logic [EVT_W-1:0]    event_count;

  modport master (
    output block, axis_block_sigs, enable, threshold, ack,
    input  irq, deadlock_active, chan_snapshot, stall_cycles, event_count
  );

  modport slave (
    input  block, axis_block_sigs, enable, threshold, ack,
    output irq, deadlock_active, chan_snapshot, stall_cycles, event_count
  );
endinterface

// File: rtl/dac_table_8x_sat_counter.sv
// Saturating counter with clear > load > increment priority.
module dac_table_8x_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                             cnt_d = '0;
    else if (load)                       cnt_d = load_val;
    else if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/dac_table_8x_deadlock_reporter.sv
// Qualifies the monitor's block indication into a latched, acked deadlock event
// with channel snapshot, stall duration and event count.
module dac_table_8x_deadlock_reporter
  import dac_table_8x_dbg_pkg::*;
#(
  parameter int NUM_AXIS = NUM_AXIS_D,
  parameter int THRESH_W = THRESH_W_D,
  parameter int DUR_W    = DUR_W_D,
  parameter int EVT_W    = EVT_W_D
) (
  input logic clock,
  input logic reset_n,
  dac_table_8x_deadlock_reporter_if.slave bus
);
  localparam int RW = THRESH_W + 1;
  localparam int LW = (RW > DUR_W) ? RW : DUR_W;

  dl_state_e           state_q, state_d;
  logic [RW-1:0]       run_cnt_q, run_cnt_d, run_nxt, thr_eff;
  logic [NUM_AXIS-1:0] acc_q, acc_d, acc_nxt;
  logic [NUM_AXIS-1:0] snap_q, snap_d;
  logic                irq_q, irq_d, active_q, active_d;
  logic                declare, stall_inc;
  logic [LW-1:0]       run_ext, dur_max_ext;
  logic [DUR_W-1:0]    stall_load, stall_cnt;
  logic [EVT_W-1:0]    evt_cnt;

  always_comb begin
    thr_eff     = (bus.threshold == '0) ? RW'(1) : {1'b0, bus.threshold};
    // Count/accumulator as they would be after including this cycle's sample.
    run_nxt     = (state_q == ST_QUALIFY) ? run_cnt_q + 1'b1 : RW'(1);
    acc_nxt     = ((state_q == ST_QUALIFY) ? acc_q : '0) | bus.axis_block_sigs;
    run_ext     = LW'(run_nxt);
    dur_max_ext = LW'({DUR_W{1'b1}});
    stall_load  = (run_ext > dur_max_ext) ? {DUR_W{1'b1}} : DUR_W'(run_nxt);

    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    acc_d     = acc_q;
    irq_d     = irq_q;
    active_d  = active_q;
    snap_d    = snap_q;
    declare   = 1'b0;
    stall_inc = 1'b0;

    if (!bus.enable) begin
      state_d   = ST_IDLE;
      run_cnt_d = '0;
      acc_d     = '0;
      irq_d     = 1'b0;
      active_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_QUALIFY: begin
          if (bus.block) begin
            if (run_nxt >= thr_eff) begin
              declare   = 1'b1;
              state_d   = ST_DEADLOCK;
              irq_d     = 1'b1;
              active_d  = 1'b1;
              snap_d    = acc_nxt;
              run_cnt_d = '0;
              acc_d     = '0;
            end else begin
              state_d   = ST_QUALIFY;
              run_cnt_d = run_nxt;
              acc_d     = acc_nxt;
            end
          end else begin
            state_d   = ST_IDLE;
            run_cnt_d = '0;
            acc_d     = '0;
          end
        end
        ST_DEADLOCK: begin
          // Once block has dropped the stall is over; a later rise is not counted.
          stall_inc = bus.block & active_q;
          active_d  = bus.block & active_q;
          if (bus.ack) begin
            irq_d   = 1'b0;
            state_d = (bus.block && active_q) ? ST_RELEASE : ST_IDLE;
          end
        end
        ST_RELEASE: begin
          if (bus.block) begin
            stall_inc = 1'b1;
          end else begin
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      run_cnt_q <= '0;
      acc_q     <= '0;
      irq_q     <= 1'b0;
      active_q  <= 1'b0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      acc_q     <= acc_d;
      irq_q     <= irq_d;
      active_q  <= active_d;
      snap_q    <= snap_d;
    end
  end

  dac_table_8x_sat_counter #(.W(DUR_W)) u_stall_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (1'b0),
    .load     (declare),
    .load_val (stall_load),
    .inc      (stall_inc),
    .q        (stall_cnt)
  );

  dac_table_8x_sat_counter #(.W(EVT_W)) u_evt_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (1'b0),
    .load     (1'b0),
    .load_val ({EVT_W{1'b0}}),
    .inc      (declare),
    .q        (evt_cnt)
  );

  assign bus.irq             = irq_q;
  assign bus.deadlock_active = active_q;
  assign bus.chan_snapshot   = snap_q;
  assign bus.stall_cycles    = stall_cnt;
  assign bus.event_count     = evt_cnt;
endmodule

// File: tb/tb_dac_table_8x_deadlock_reporter.sv
// Directed bench for the deadlock reporter: a streak-based reference model checked
// every cycle, plus hand-computed literal checkpoints.
module tb_dac_table_8x_deadlock_reporter;
  localparam int NA = 3;
  localparam int TW = 16;
  localparam int DW = 6;
  localparam int EW = 2;
  localparam int STALL_MAX = (1 << DW) - 1;
  localparam int EV_MAX    = (1 << EW) - 1;

  logic clock = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  dac_table_8x_deadlock_reporter_if #(.NUM_AXIS(NA), .THRESH_W(TW), .DUR_W(DW), .EVT_W(EW)) bus ();

  dac_table_8x_deadlock_reporter #(.NUM_AXIS(NA), .THRESH_W(TW), .DUR_W(DW), .EVT_W(EW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = hunting for a streak, 1 = latched event, 2 = acked but still stalled.
  int       m_phase  = 0;
  int       m_streak = 0;
  int       m_acc    = 0;
  int       m_irq    = 0;
  int       m_act    = 0;
  int       m_snap   = 0;
  int       m_stall  = 0;
  int       m_ev     = 0;

  always @(posedge clock or negedge reset_n) begin
    int eff;
    if (!reset_n) begin
      m_phase = 0; m_streak = 0; m_acc = 0; m_irq = 0;
      m_act = 0; m_snap = 0; m_stall = 0; m_ev = 0;
    end else if (!bus.enable) begin
      m_phase = 0; m_streak = 0; m_acc = 0; m_irq = 0; m_act = 0;
    end else begin
      eff = (bus.threshold == 0) ? 1 : int'(bus.threshold);
      if (m_phase == 0) begin
        if (bus.block) begin
          m_streak++;
          m_acc |= int'(bus.axis_block_sigs);
          if (m_streak >= eff) begin
            m_phase = 1; m_irq = 1; m_act = 1; m_snap = m_acc;
            m_stall = (m_streak > STALL_MAX) ? STALL_MAX : m_streak;
            m_ev    = (m_ev < EV_MAX) ? m_ev + 1 : EV_MAX;
            m_streak = 0; m_acc = 0;
          end
        end else begin
          m_streak = 0; m_acc = 0;
        end
      end else if (m_phase == 1) begin
        if (bus.block && m_act) begin
          if (m_stall < STALL_MAX) m_stall++;
        end else begin
          m_act = 0;
        end
        if (bus.ack) begin
          m_irq   = 0;
          m_phase = m_act ? 2 : 0;
        end
      end else begin
        if (bus.block) begin
          if (m_stall < STALL_MAX) m_stall++;
        end else begin
          m_act = 0; m_phase = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("cyc_irq",    bus.irq,             m_irq);
    chk("cyc_active", bus.deadlock_active, m_act);
    chk("cyc_snap",   bus.chan_snapshot,   m_snap);
    chk("cyc_stall",  bus.stall_cycles,    m_stall);
    chk("cyc_events", bus.event_count,     m_ev);
  end

  task automatic drv(input logic b, input logic [NA-1:0] s, input logic a);
    bus.block = b;
    bus.axis_block_sigs = s;
    bus.ack = a;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_outs(input string nm, input int irq, input int act,
                          input int snap, input int stall, input int ev);
    chk({nm, "_irq"},    bus.irq,             irq);
    chk({nm, "_active"}, bus.deadlock_active, act);
    chk({nm, "_snap"},   bus.chan_snapshot,   snap);
    chk({nm, "_stall"},  bus.stall_cycles,    stall);
    chk({nm, "_events"}, bus.event_count,     ev);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.block = 1'b0; bus.axis_block_sigs = '0; bus.enable = 1'b1;
    bus.threshold = 16'd4; bus.ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Transient stall shorter than the threshold.
    repeat (3) drv(1'b1, 3'b001, 1'b0);
    drv(1'b0, 3'b000, 1'b0);
    chk_outs("transient", 0, 0, 0, 0, 0);
    drv(1'b0, 3'b000, 1'b0);

    // Ten-cycle stall, channels 0 then 2.
    repeat (2) drv(1'b1, 3'b001, 1'b0);
    drv(1'b1, 3'b100, 1'b0);
    chk("t2_irq_early", bus.irq, 0);
    drv(1'b1, 3'b100, 1'b0);
    chk_outs("t2_declare", 1, 1, 5, 4, 1);
    repeat (6) drv(1'b1, 3'b100, 1'b0);
    drv(1'b0, 3'b000, 1'b0);
    chk_outs("t2_fall", 1, 0, 5, 10, 1);
    drv(1'b0, 3'b000, 1'b1);
    chk_outs("t2_ack", 0, 0, 5, 10, 1);
    drv(1'b0, 3'b000, 1'b0);

    // Threshold 0 behaves as 1: single-cycle pulse declares.
    bus.threshold = 16'd0;
    drv(1'b1, 3'b010, 1'b0);
    chk_outs("thr0", 1, 1, 2, 1, 2);
    drv(1'b0, 3'b000, 1'b0);
    drv(1'b0, 3'b000, 1'b1);
    drv(1'b0, 3'b000, 1'b0);
    bus.threshold = 16'd4;

    // Async reset mid-cycle while a deadlock is active, block held throughout.
    repeat (4) drv(1'b1, 3'b001, 1'b0);
    chk("t5_pre_irq", bus.irq, 1);
    chk("t5_pre_ev", bus.event_count, 3);
    #2 reset_n = 1'b0;
    #1 chk_outs("async_rst", 0, 0, 0, 0, 0);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    repeat (2) drv(1'b1, 3'b001, 1'b0);
    chk("requal_irq_early", bus.irq, 0);
    drv(1'b1, 3'b001, 1'b0);
    chk_outs("requal_declare", 1, 1, 1, 4, 1);

    // Ack while still blocked, then a long stall with no second event.
    drv(1'b1, 3'b001, 1'b1);
    chk_outs("ack_high", 0, 1, 1, 5, 1);
    repeat (60) drv(1'b1, 3'b001, 1'b0);
    chk_outs("release_long", 0, 1, 1, STALL_MAX, 1);
    drv(1'b0, 3'b000, 1'b0);
    chk_outs("release_fall", 0, 0, 1, STALL_MAX, 1);
    drv(1'b0, 3'b000, 1'b0);

    // Repeated declare/ack with simultaneous block fall: event counter saturates.
    for (int i = 0; i < 5; i++) begin
      repeat (4) drv(1'b1, 3'b001, 1'b0);
      drv(1'b0, 3'b000, 1'b1);
      chk("sat_ackfall_irq", bus.irq, 0);
      chk("sat_ackfall_act", bus.deadlock_active, 0);
      drv(1'b0, 3'b000, 1'b0);
    end
    chk_outs("evt_sat", 0, 0, 1, 4, 3);

    // Enable dropped mid-qualify: no declaration, status retained.
    repeat (2) drv(1'b1, 3'b110, 1'b0);
    bus.enable = 1'b0;
    drv(1'b1, 3'b110, 1'b0);
    bus.enable = 1'b1;
    repeat (3) drv(1'b1, 3'b110, 1'b0);
    drv(1'b0, 3'b000, 1'b0);
    chk_outs("en_qualify", 0, 0, 1, 4, 3);

    // Enable dropped in deadlock clears flags only.
    repeat (4) drv(1'b1, 3'b010, 1'b0);
    bus.enable = 1'b0;
    drv(1'b1, 3'b010, 1'b0);
    chk_outs("en_deadlock", 0, 0, 2, 4, 3);
    bus.enable = 1'b1;
    drv(1'b0, 3'b000, 1'b0);
    drv(1'b0, 3'b000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dac_table_8x_deadlock_reporter.md
Name: dac_table_8x_deadlock_reporter

Overview:
Consumes the single-bit block indication produced by the dac_table_8x deadlock monitor and turns it into a qualified, software-visible deadlock event. It filters transient stalls with a persistence threshold, snapshots which AXIS channel(s) were blocked, and measures how long the stall lasted. It raises a level interrupt, which is cleared through an acknowledge handshake. It sits beside the dac_table_8x instance, and its outputs feed the control/status register bank.

Parameters:
NUM_AXIS, 3, number of AXIS block signals snapshotted
THRESH_W, 16, width of persistence threshold input
DUR_W, 32, width of stall duration counter (saturating)
EVT_W, 8, width of deadlock event counter (saturating)

Ports:
clock  in  1  single clock domain
reset_n  in  1  asynchronous, active-low reset
block  in  1  monitor output, high while a blocking condition is seen
axis_block_sigs  in  NUM_AXIS  per-channel AXIS block flags, same cycle as block
enable  in  1  reporter armed; low forces IDLE
threshold  in  THRESH_W  consecutive block cycles required to declare deadlock; 0 treated as 1
ack  in  1  single-cycle acknowledge from software
irq  out  1  level interrupt, high in DEADLOCK state
deadlock_active  out  1  high while a declared deadlock persists
chan_snapshot  out  NUM_AXIS  OR of axis_block_sigs over the qualifying window, latched at declaration
stall_cycles  out  DUR_W  cycles block stayed high for the last/current event, saturating
event_count  out  EVT_W  number of declared deadlocks since reset, saturating

Behaviour:
- Reset (reset_n low, async): state IDLE; all outputs 0; internal counters 0.
- States: IDLE, QUALIFY, DEADLOCK, RELEASE.
- IDLE: run_cnt=0, acc=0. If enable and block: go to QUALIFY, run_cnt=1, acc=axis_block_sigs.
- QUALIFY, with block high:
  - run_cnt+1, acc|=axis_block_sigs.
  - When run_cnt reaches max(threshold,1), declare on that edge: go to DEADLOCK, irq=1, deadlock_active=1, chan_snapshot=acc (including the current cycle), stall_cycles=run_cnt, event_count+1 (saturating).
  - Declaration latency is therefore exactly max(threshold,1) consecutive block cycles after block first rises, with irq visible on the next clock edge.
- QUALIFY, with block low: return to IDLE and discard. No output changes.
- threshold is sampled on every comparison. Lowering it mid-QUALIFY below run_cnt declares on the next cycle.
- DEADLOCK:
  - stall_cycles increments every block-high cycle, saturating at all-ones.
  - If block falls: deadlock_active=0 and irq stays high; remain in DEADLOCK until acked.
  - ack with block low: irq=0, go to IDLE.
  - ack with block high: irq=0, go to RELEASE.
- RELEASE: irq=0, deadlock_active=1, stall_cycles keeps counting. When block falls: deadlock_active=0, go to IDLE. No re-declaration without a fresh low-to-high sequence.
- ack outside DEADLOCK is ignored.
- chan_snapshot and stall_cycles hold their last value until the next declaration. At declaration they are overwritten, and stall_cycles restarts from run_cnt.
- enable low: force IDLE from any state on the next edge; irq=0, deadlock_active=0. Snapshot, stall_cycles and event_count are retained.
- Simultaneous ack and block-fall in DEADLOCK: go to IDLE, both flags 0.
- Saturation:
  - event_count holds at 2^EVT_W-1.
  - stall_cycles holds at 2^DUR_W-1.
  - run_cnt is THRESH_W+1 bits wide and cannot overflow before the compare.
- All outputs are registered. No combinational path from input to output.

Decomposition:
- Shared package dac_table_8x_dbg_pkg holds:
  - a state enum for the four states;
  - default widths as constants (NUM_AXIS=3, THRESH_W, DUR_W, EVT_W).
- One natural sub-module: dac_table_8x_sat_counter, a parameterized width saturating counter with load/clear/inc. It is instantiated for stall_cycles and event_count.

Test Plan:
- threshold=4, block high 3 cycles then low → no irq, event_count=0, state returns IDLE.
- threshold=4, block high 10 cycles with axis_block_sigs=3'b001 for 2 cycles then 3'b100 → irq rises on the edge after the 4th high cycle, chan_snapshot=3'b101, event_count=1, stall_cycles=10 after block falls.
- Deadlock declared, ack while block still high → irq=0 next cycle, deadlock_active stays 1 until block falls; block held high 50 more cycles yields no second event (event_count=1).
- threshold=0, single-cycle block pulse → declared (treated as 1), irq=1, stall_cycles=1.
- Deadlock active, assert reset_n low asynchronously mid-cycle → all outputs 0 immediately, without waiting for a clock edge; after release, block must re-qualify from 0.
- EVT_W=2, produce 5 declare/ack cycles → event_count saturates at 3. Also drop enable during QUALIFY → no declaration and counters are retained.
